// File: rtl/v850_pkg.sv
// Shared types and op decode helpers for the V850 memory-access stage.
// Combinational helpers only; no latency.
// No flow control of its own.
package v850_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LD_B     = 4'd1,
        LD_BU    = 4'd2,
        LD_H     = 4'd3,
        LD_HU    = 4'd4,
        LD_W     = 4'd5,
        ST_B     = 4'd6,
        ST_H     = 4'd7,
        ST_W     = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } ma_state_e;

    function automatic logic is_load(input mem_op_e op);
        return (op == LD_B) || (op == LD_BU) || (op == LD_H) ||
               (op == LD_HU) || (op == LD_W);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == ST_B) || (op == ST_H) || (op == ST_W);
    endfunction

    function automatic mem_size_e op_size(input mem_op_e op);
        case (op)
            LD_B, LD_BU, ST_B: return SZ_B;
            LD_H, LD_HU, ST_H: return SZ_H;
            LD_W, ST_W:        return SZ_W;
            default:           return SZ_NONE;
        endcase
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
        case (op_size(op))
            SZ_H:    return a[0];
            SZ_W:    return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input mem_op_e op, input logic [1:0] a);
        case (op_size(op))
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            SZ_W:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Replicate narrow store data so every lane carries it; be selects the live lane.
    function automatic logic [31:0] store_lanes(input mem_op_e op, input logic [31:0] d);
        case (op_size(op))
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_aligner.sv
// Shifts the addressed bytes of a read word down to bit 0 and sign/zero-extends them.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module load_aligner
    import v850_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Extend the low byte/halfword according to the load flavour; words pass as-is.
    always_comb begin
        data = shifted;
        case (mem_op_e'(op))
            LD_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            LD_BU:   data = {24'h000000, shifted[7:0]};
            LD_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            LD_HU:   data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// V850 memory-access stage: runs loads/stores on a req/ack bus, forwards results to writeback.
// Latency: non-memory and misaligned ops 1 cycle; bus ops 2 cycles minimum (accept, ack, valid_o).
// Backpressure: ready_o low while a bus access is outstanding; MEM_BUS_TIMEOUT_EN enables abort.
module memory_access
    import v850_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] result_i,
    input  logic [31:0] result2_i,
    input  logic [4:0]  destination_i,
    input  logic [4:0]  destination2_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [31:0] result2_o,
    output logic [4:0]  destination_o,
    output logic [4:0]  destination2_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    ma_state_e   state_q, state_d;
    mem_op_e     op;
    logic        is_mem;
    logic        misaligned;
    logic        start_access;
    logic        expire;
    logic        timeout_q;

    // Context of the outstanding access, needed when the ack returns.
    mem_op_e     op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] result2_q;
    logic [4:0]  dest_q;
    logic [4:0]  dest2_q;
    logic [31:0] load_data;

    assign op           = mem_op_e'(op_i);
    assign is_mem       = is_load(op) || is_store(op);
    assign misaligned   = is_misaligned(op, addr_i[1:0]);
    assign ready_o      = (state_q == S_IDLE);
    assign start_access = valid_i && ready_o && is_mem && !misaligned;
    assign timeout_o    = timeout_q;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Ack on the expiry edge takes priority, so expiry requires no ack.
    assign expire = (state_q == S_ACCESS) && !dmem_ack_i &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles without ack; held at zero while idle so each access starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_q == S_IDLE) begin
            tmo_cnt <= '0;
        end else if (!dmem_ack_i) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign expire             = 1'b0;
`endif

    load_aligner u_load_aligner (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .rdata   (dmem_rdata_i),
        .data    (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter ACCESS on an aligned bus op, leave on ack or expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_access) state_d = S_ACCESS;
            S_ACCESS: if (dmem_ack_i || expire) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus drive, access context and writeback outputs; flags are one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_be_o      <= 4'h0;
            dmem_addr_o    <= 32'h0;
            dmem_wdata_o   <= 32'h0;
            valid_o        <= 1'b0;
            result_o       <= 32'h0;
            result2_o      <= 32'h0;
            destination_o  <= 5'd0;
            destination2_o <= 5'd0;
            misalign_o     <= 1'b0;
            timeout_q      <= 1'b0;
            op_q           <= MEM_NONE;
            addr_lo_q      <= 2'b00;
            result2_q      <= 32'h0;
            dest_q         <= 5'd0;
            dest2_q        <= 5'd0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            timeout_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (valid_i && !is_mem) begin
                    valid_o        <= 1'b1;
                    result_o       <= result_i;
                    result2_o      <= result2_i;
                    destination_o  <= destination_i;
                    destination2_o <= destination2_i;
                end else if (valid_i && misaligned) begin
                    valid_o        <= 1'b1;
                    misalign_o     <= 1'b1;
                    result_o       <= result_i;
                    result2_o      <= result2_i;
                    destination_o  <= 5'd0;
                    destination2_o <= 5'd0;
                end else if (start_access) begin
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= is_store(op);
                    dmem_be_o    <= byte_enable(op, addr_i[1:0]);
                    dmem_addr_o  <= {addr_i[31:2], 2'b00};
                    dmem_wdata_o <= store_lanes(op, store_data_i);
                    op_q         <= op;
                    addr_lo_q    <= addr_i[1:0];
                    result2_q    <= result2_i;
                    dest_q       <= destination_i;
                    dest2_q      <= destination2_i;
                end
            end else begin
                if (dmem_ack_i) begin
                    dmem_req_o     <= 1'b0;
                    valid_o        <= 1'b1;
                    result_o       <= is_load(op_q) ? load_data : 32'h0;
                    destination_o  <= is_load(op_q) ? dest_q : 5'd0;
                    result2_o      <= result2_q;
                    destination2_o <= dest2_q;
                end else if (expire) begin
                    dmem_req_o     <= 1'b0;
                    valid_o        <= 1'b1;
                    timeout_q      <= 1'b1;
                    result_o       <= 32'h0;
                    result2_o      <= result2_q;
                    destination_o  <= 5'd0;
                    destination2_o <= 5'd0;
                end
            end
        end
    end

endmodule
